// File: rtl/alu_add_seq_if.sv
// ---------------------------------------------------------------------------
// alu_add_seq_if
// Handshake and operand/result bundle between the instruction controller
// (master) and the nibble-serial adder (slave).
//
//   start    master->slave  request an addition (sampled when not busy)
//   x, y     master->slave  WIDTH-bit operands, captured on accept
//   cin      master->slave  carry into nibble 0, captured on accept
//   busy     slave->master  nibbles being processed
//   done     slave->master  one-cycle completion pulse
//   z        slave->master  registered sum
//   sign, zero, carry, parity, overflow
//            slave->master  registered status flags
// ---------------------------------------------------------------------------
interface alu_add_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             sign;
  logic             zero;
  logic             carry;
  logic             parity;
  logic             overflow;

  modport master (
    output start, x, y, cin,
    input  busy, done, z, sign, zero, carry, parity, overflow
  );

  modport slave (
    input  start, x, y, cin,
    output busy, done, z, sign, zero, carry, parity, overflow
  );
endinterface

// File: rtl/alu_add_seq.sv
// ---------------------------------------------------------------------------
// alu_add_seq
// Nibble-serial 16-bit (WIDTH-bit) adder. A single 4-bit ripple slice is
// reused over WIDTH/4 cycles; the carry between nibbles is held in a
// register, so the longest combinational path is one 4-bit ripple.
// Produces Sign, Zero, Carry, Parity (even) and Overflow flags.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   alu_add_seq_if.slave: start/x/y/cin in, busy/done/z/flags out
//
// WIDTH must be a multiple of 4 (and at least 4).
// ---------------------------------------------------------------------------
module alu_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_add_seq_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] xw_q, xw_d;     // captured operand X
  logic [WIDTH-1:0] yw_q, yw_d;     // captured operand Y
  logic [WIDTH-1:0] sum_q, sum_d;   // working sum, filled nibble by nibble
  logic             cr_q, cr_d;     // inter-nibble carry
  logic [WIDTH-1:0] z_q, z_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             parity_q, parity_d;
  logic             ovf_q, ovf_d;

  // -------------------------------------------------------------------------
  // Shared 4-bit ripple slice
  // -------------------------------------------------------------------------
  logic [3:0] a_nib, b_nib, s_nib;
  logic [4:0] c_chain;

  assign a_nib      = 4'(xw_q >> {k_q, 2'b00});
  assign b_nib      = 4'(yw_q >> {k_q, 2'b00});
  assign c_chain[0] = cr_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s_nib[gi]     = a_nib[gi] ^ b_nib[gi] ^ c_chain[gi];
      assign c_chain[gi+1] = (a_nib[gi] & b_nib[gi]) |
                             (c_chain[gi] & (a_nib[gi] ^ b_nib[gi]));
    end
  endgenerate

  logic k_last;
  assign k_last = (k_q == KW'(NIB - 1));

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    xw_d     = xw_q;
    yw_d     = yw_q;
    sum_d    = sum_q;
    cr_d     = cr_q;
    z_d      = z_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    parity_d = parity_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request directly so back-to-back adds have
        // no idle bubble.
        if (bus.start) begin
          xw_d    = bus.x;
          yw_d    = bus.y;
          cr_d    = bus.cin;
          k_d     = '0;
          sum_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (k_q == KW'(i)) sum_d[i*4 +: 4] = s_nib;
        end
        cr_d = c_chain[4];
        if (k_last) begin
          // Commit: sum_d now holds the complete result. Overflow uses the
          // captured operand MSBs, never the live bus inputs.
          z_d      = sum_d;
          sign_d   = sum_d[WIDTH-1];
          zero_d   = (sum_d == '0);
          carry_d  = c_chain[4];
          parity_d = ~^sum_d;
          ovf_d    = ( xw_q[WIDTH-1] &  yw_q[WIDTH-1] & ~sum_d[WIDTH-1]) |
                     (~xw_q[WIDTH-1] & ~yw_q[WIDTH-1] &  sum_d[WIDTH-1]);
          k_d      = '0;
          state_d  = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      xw_q     <= '0;
      yw_q     <= '0;
      sum_q    <= '0;
      cr_q     <= 1'b0;
      z_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      parity_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      xw_q     <= xw_d;
      yw_q     <= yw_d;
      sum_q    <= sum_d;
      cr_q     <= cr_d;
      z_q      <= z_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      parity_q <= parity_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.z        = z_q;
  assign bus.sign     = sign_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.parity   = parity_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_add_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_add_seq
// Directed-vector bench for alu_add_seq (WIDTH=16). Expected sums and flags
// are hand-computed constants. Flags are compared packed as
// {sign, zero, carry, parity, overflow}.
// ---------------------------------------------------------------------------
module tb_alu_add_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_add_seq_if #(.WIDTH(16)) bus ();

  alu_add_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Presents operands with start for one cycle, then
  // scrambles the inputs to prove they were captured. Returns the number of
  // edges after the accept edge until done is seen (-1 on timeout) and the
  // number of busy cycles observed. Leaves the bench at the done negedge.
  task automatic run_add(input logic [15:0] xv, input logic [15:0] yv,
                         input logic cv, output int lat, output int busy_n);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    bus.cin   = cv;
    lat       = -1;
    busy_n    = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0) begin
        bus.start = 1'b0;
        bus.x     = 16'hDEAD;
        bus.y     = 16'hBEEF;
        bus.cin   = 1'b1;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int gap;
    logic seen_done;

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state (parity/zero are registered and read 0)
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_z",     32'(bus.z), 32'h0);
    chk("rst_flags", 32'(flags()), 32'b00000);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with latency/busy-length checks
    run_add(16'h1234, 16'h4321, 1'b0, lat, busy_n);
    chk("basic_lat",   32'(lat), 32'd4);
    chk("basic_busy",  32'(busy_n), 32'd4);
    chk("basic_z",     32'(bus.z), 32'h5555);
    chk("basic_flags", 32'(flags()), 32'b00010);
    @(negedge clk);
    chk("done_1cycle", 32'(bus.done), 32'd0);
    chk("hold_z",      32'(bus.z), 32'h5555);

    // Wrap to zero
    run_add(16'hFFFF, 16'h0001, 1'b0, lat, busy_n);
    chk("wrap_z",     32'(bus.z), 32'h0000);
    chk("wrap_flags", 32'(flags()), 32'b01110);
    @(negedge clk);

    // Signed overflow, positive
    run_add(16'h7FFF, 16'h0001, 1'b0, lat, busy_n);
    chk("ovfp_z",     32'(bus.z), 32'h8000);
    chk("ovfp_flags", 32'(flags()), 32'b10001);
    @(negedge clk);

    // Signed overflow, negative
    run_add(16'h8000, 16'h8000, 1'b0, lat, busy_n);
    chk("ovfn_z",     32'(bus.z), 32'h0000);
    chk("ovfn_flags", 32'(flags()), 32'b01111);
    @(negedge clk);

    // Carry-in rippling across all nibble boundaries
    run_add(16'h0FFF, 16'h0000, 1'b1, lat, busy_n);
    chk("cin_z",     32'(bus.z), 32'h1000);
    chk("cin_flags", 32'(flags()), 32'b00000);
    @(negedge clk);

    // Handshake: start pulses during busy cycles 1-3 are ignored
    bus.start = 1'b1;
    bus.x     = 16'h00FF;
    bus.y     = 16'h0001;
    bus.cin   = 1'b0;
    lat       = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      bus.start = (n < 3);
      bus.x     = 16'hFFFF;
      bus.y     = 16'hFFFF;
      bus.cin   = 1'b1;
      if (n == 1) chk("run_z_stable", 32'(bus.z), 32'h1000);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    chk("ign_lat",   32'(lat), 32'd4);
    chk("ign_z",     32'(bus.z), 32'h0100);
    chk("ign_flags", 32'(flags()), 32'b00000);

    // Back-to-back: start in the DONE cycle
    bus.start = 1'b1;
    bus.x     = 16'h0001;
    bus.y     = 16'h0002;
    bus.cin   = 1'b0;
    gap       = -1;
    for (int n = 1; n < 20; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 1) chk("b2b_nobubble", 32'(bus.busy), 32'd1);
      if (n == 2) chk("b2b_hold_z", 32'(bus.z), 32'h0100);
      if (bus.done) begin
        gap = n;
        break;
      end
    end
    chk("b2b_gap",   32'(gap), 32'd5);
    chk("b2b_z",     32'(bus.z), 32'h0003);
    chk("b2b_flags", 32'(flags()), 32'b00010);
    @(negedge clk);

    // Reset in busy cycle 2 aborts the add
    bus.start = 1'b1;
    bus.x     = 16'h1111;
    bus.y     = 16'h2222;
    @(negedge clk);            // busy cycle 1
    bus.start = 1'b0;
    @(negedge clk);            // busy cycle 2
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.start = 1'b1;          // reset must win over start
    @(negedge clk);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd0);
    chk("abort_z",     32'(bus.z), 32'h0);
    chk("abort_flags", 32'(flags()), 32'b00000);
    rst       = 1'b0;
    bus.start = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("abort_quiet", 32'(seen_done), 32'd0);

    // Normal operation after the abort
    run_add(16'h0001, 16'h0001, 1'b0, lat, busy_n);
    chk("post_lat",   32'(lat), 32'd4);
    chk("post_z",     32'(bus.z), 32'h0002);
    chk("post_flags", 32'(flags()), 32'b00000);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
